// File: rtl/regbank_pkg.sv
// Shared types and helpers for the parametrised integer register bank.
package regbank_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = 5;

  // True when addr names an implemented register slot (x0 included).
  function automatic logic addr_valid(input logic [31:0] addr, input int nregs);
    return addr < 32'(nregs);
  endfunction

endpackage

// File: rtl/regbank_rdport.sv
// One combinational read port: x0 and out-of-range indices read zero,
// optional same-cycle forwarding of the writeback value.
module regbank_rdport
  import regbank_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int AW     = AW_DEF,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]   raddr,
  input  logic [XLEN-1:0] regs [2**AW],
  input  logic            fwd_en,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);

  logic in_range;
  logic fwd_hit;

  // A matching, non-zero, in-range raddr implies waddr is a real register too.
  always_comb begin
    in_range = addr_valid(32'(raddr), NREGS);
    fwd_hit  = (BYPASS != 0) && fwd_en && (raddr == waddr);
    rdata    = '0;
    if ((raddr != '0) && in_range) begin
      rdata = fwd_hit ? wdata : regs[raddr];
    end
  end

endmodule

// File: rtl/reg_bank_param.sv
// Parametrised register file with NRD read ports, one write port and a
// sequenced bulk-clear engine that zeroes x1..x(NREGS-1) one per cycle.
module reg_bank_param
  import regbank_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  parameter int AW     = AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*XLEN-1:0] rdata,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done
);

  localparam logic [AW-1:0] LAST_IDX     = AW'(NREGS - 1);
  localparam logic [AW-1:0] PRE_LAST_IDX = AW'(NREGS - 2);

  state_t          state_reg;
  logic [AW-1:0]   cnt_reg;
  logic            busy_reg;
  logic            clr_done_reg;
  logic            fwd_en;
  logic [XLEN-1:0] regs_view [2**AW];

  assign fwd_en   = we && (state_reg == IDLE);
  assign busy     = busy_reg;
  assign clr_done = clr_done_reg;

  // Slot 0 and slots beyond NREGS have no storage and present constant zero.
  for (genvar gi = 0; gi < 2**AW; gi++) begin : g_slot
    if (gi >= 1 && gi < NREGS) begin : g_store
      logic [XLEN-1:0] q_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_reg <= '0;
        end else if ((state_reg == CLEAR) && (cnt_reg == AW'(gi))) begin
          q_reg <= '0;
        end else if (fwd_en && (waddr == AW'(gi))) begin
          q_reg <= wdata;
        end
      end
      assign regs_view[gi] = q_reg;
    end else begin : g_zero
      assign regs_view[gi] = '0;
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    regbank_rdport #(
      .XLEN   (XLEN),
      .NREGS  (NREGS),
      .AW     (AW),
      .BYPASS (BYPASS)
    ) u_rdport (
      .raddr  (raddr[gi*AW +: AW]),
      .regs   (regs_view),
      .fwd_en (fwd_en),
      .waddr  (waddr),
      .wdata  (wdata),
      .rdata  (rdata[gi*XLEN +: XLEN])
    );
  end

  // clr_done is raised one edge early so it is high during the final clear cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= AW'(1);
      busy_reg     <= 1'b0;
      clr_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg    <= clr_req ? CLEAR : IDLE;
          busy_reg     <= clr_req;
          clr_done_reg <= clr_req && (NREGS == 2);
        end
        CLEAR: begin
          if (cnt_reg == LAST_IDX) begin
            state_reg    <= IDLE;
            cnt_reg      <= AW'(1);
            busy_reg     <= 1'b0;
            clr_done_reg <= 1'b0;
          end else begin
            cnt_reg      <= cnt_reg + AW'(1);
            clr_done_reg <= (cnt_reg == PRE_LAST_IDX);
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_param.sv
// Directed bench for reg_bank_param across four configurations, using an
// expected-value queue drained at each sample point.
module tb_reg_bank_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // u0: default 32x32, NRD=2, bypass on
  logic we0, clr0, busy0, done0;
  logic [4:0] waddr0;
  logic [31:0] wdata0;
  logic [9:0] raddr0;
  logic [63:0] rdata0;
  // u1: NREGS=20, NRD=1, bypass off
  logic we1, clr1, busy1, done1;
  logic [4:0] waddr1;
  logic [31:0] wdata1;
  logic [4:0] raddr1;
  logic [31:0] rdata1;
  // u2: NREGS=16, AW=4, NRD=3
  logic we2, clr2, busy2, done2;
  logic [3:0] waddr2;
  logic [31:0] wdata2;
  logic [11:0] raddr2;
  logic [95:0] rdata2;
  // u3: NREGS=2, AW=1, XLEN=8
  logic we3, clr3, busy3, done3;
  logic [0:0] waddr3;
  logic [7:0] wdata3;
  logic [0:0] raddr3;
  logic [7:0] rdata3;

  reg_bank_param #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1), .AW(5)) u0 (
    .clk(clk), .rst_n(rst_n), .we(we0), .waddr(waddr0), .wdata(wdata0), .raddr(raddr0),
    .rdata(rdata0), .clr_req(clr0), .busy(busy0), .clr_done(done0));
  reg_bank_param #(.XLEN(32), .NREGS(20), .NRD(1), .BYPASS(0), .AW(5)) u1 (
    .clk(clk), .rst_n(rst_n), .we(we1), .waddr(waddr1), .wdata(wdata1), .raddr(raddr1),
    .rdata(rdata1), .clr_req(clr1), .busy(busy1), .clr_done(done1));
  reg_bank_param #(.XLEN(32), .NREGS(16), .NRD(3), .BYPASS(1), .AW(4)) u2 (
    .clk(clk), .rst_n(rst_n), .we(we2), .waddr(waddr2), .wdata(wdata2), .raddr(raddr2),
    .rdata(rdata2), .clr_req(clr2), .busy(busy2), .clr_done(done2));
  reg_bank_param #(.XLEN(8), .NREGS(2), .NRD(1), .BYPASS(1), .AW(1)) u3 (
    .clk(clk), .rst_n(rst_n), .we(we3), .waddr(waddr3), .wdata(wdata3), .raddr(raddr3),
    .rdata(rdata3), .clr_req(clr3), .busy(busy3), .clr_done(done3));

  localparam int P_BUSY = 8;
  localparam int P_DONE = 9;

  typedef struct {
    string       tag;
    int          unit_id;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [31:0] observe(input int u, input int p);
    logic [31:0] v;
    v = 32'hDEAD_0000;
    case (u)
      0: if (p == P_BUSY) v = 32'(busy0); else if (p == P_DONE) v = 32'(done0);
         else v = 32'(rdata0 >> (p * 32));
      1: if (p == P_BUSY) v = 32'(busy1); else if (p == P_DONE) v = 32'(done1);
         else v = rdata1;
      2: if (p == P_BUSY) v = 32'(busy2); else if (p == P_DONE) v = 32'(done2);
         else v = 32'(rdata2 >> (p * 32));
      3: if (p == P_BUSY) v = 32'(busy3); else if (p == P_DONE) v = 32'(done3);
         else v = 32'(rdata3);
      default: v = 32'hDEAD_0000;
    endcase
    return v;
  endfunction

  task automatic expect_val(input string tag, input int u, input int p, input logic [31:0] e);
    exp_t x;
    x.tag = tag; x.unit_id = u; x.port = p; x.exp = e;
    sbq.push_back(x);
  endtask

  task automatic check_all();
    exp_t x;
    logic [31:0] got;
    while (sbq.size() > 0) begin
      x = sbq.pop_front();
      got = observe(x.unit_id, x.port);
      vectors++;
      assert (got === x.exp) else begin
        miscompares++;
        $error("FAIL %s (u%0d p%0d): observed %h expected %h", x.tag, x.unit_id, x.port, got, x.exp);
      end
    end
  endtask

  task automatic check_int(input string tag, input int got, input int e);
    vectors++;
    assert (got === e) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic note(input string s);
    $display("step: %s", s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bcnt, dcnt, dpos;
    rst_n = 1'b0;
    we0 = 0; clr0 = 0; waddr0 = '0; wdata0 = '0; raddr0 = '0;
    we1 = 0; clr1 = 0; waddr1 = '0; wdata1 = '0; raddr1 = '0;
    we2 = 0; clr2 = 0; waddr2 = '0; wdata2 = '0; raddr2 = '0;
    we3 = 0; clr3 = 0; waddr3 = '0; wdata3 = '0; raddr3 = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    note("async reset mid-cycle");
    we0 = 1; waddr0 = 5'd5; wdata0 = 32'h1; tick();
    we0 = 0; raddr0 = {5'd5, 5'd5}; #2;
    expect_val("pre_reset_x5", 0, 0, 32'h1);
    check_all();
    #1 rst_n = 1'b0; #1;
    expect_val("async_rst_p0", 0, 0, 32'h0);
    expect_val("async_rst_p1", 0, 1, 32'h0);
    expect_val("async_rst_busy", 0, P_BUSY, 32'h0);
    expect_val("async_rst_done", 0, P_DONE, 32'h0);
    check_all();
    tick();
    rst_n = 1'b1;
    tick();

    note("read sweep after reset");
    for (int i = 0; i < 32; i++) begin
      raddr0 = {5'(31 - i), 5'(i)}; #2;
      expect_val("rst_sweep_p0", 0, 0, 32'h0);
      expect_val("rst_sweep_p1", 0, 1, 32'h0);
      check_all();
      tick();
    end

    note("write x5 then x0");
    we0 = 1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; tick();
    waddr0 = 5'd0; wdata0 = 32'h1234; raddr0 = {5'd0, 5'd5}; #2;
    expect_val("x5_written", 0, 0, 32'hDEADBEEF);
    expect_val("x0_no_bypass", 0, 1, 32'h0);
    check_all();
    tick();
    we0 = 0; raddr0 = {5'd5, 5'd5}; #2;
    expect_val("x5_p0", 0, 0, 32'hDEADBEEF);
    expect_val("x5_p1", 0, 1, 32'hDEADBEEF);
    check_all();
    raddr0 = '0; #1;
    expect_val("x0_p0", 0, 0, 32'h0);
    expect_val("x0_p1", 0, 1, 32'h0);
    check_all();
    tick();

    note("bypass on / off");
    raddr0 = {5'd5, 5'd7}; we0 = 1; waddr0 = 5'd7; wdata0 = 32'hA5A5A5A5;
    raddr1 = 5'd7; we1 = 1; waddr1 = 5'd7; wdata1 = 32'hA5A5A5A5; #2;
    expect_val("bypass_hit", 0, 0, 32'hA5A5A5A5);
    expect_val("bypass_other_port", 0, 1, 32'hDEADBEEF);
    expect_val("nobypass_old", 1, 0, 32'h0);
    check_all();
    tick();
    we0 = 0; we1 = 0; #2;
    expect_val("x7_committed_u0", 0, 0, 32'hA5A5A5A5);
    expect_val("x7_committed_u1", 1, 0, 32'hA5A5A5A5);
    check_all();

    note("range boundary on NREGS=20");
    we1 = 1; waddr1 = 5'd25; wdata1 = 32'hFFFFFFFF; raddr1 = 5'd25; tick();
    waddr1 = 5'd19; wdata1 = 32'h19; tick();
    we1 = 0; #2;
    expect_val("oor_read", 1, 0, 32'h0);
    check_all();
    raddr1 = 5'd19; #1;
    expect_val("top_valid_reg", 1, 0, 32'h19);
    check_all();
    tick();

    note("bulk clear of 32-entry bank");
    we0 = 1;
    for (int i = 1; i < 32; i++) begin
      waddr0 = 5'(i); wdata0 = 32'(i * 3); tick();
    end
    we0 = 0; clr0 = 1; tick();
    clr0 = 0;
    for (int k = 1; k <= 31; k++) begin
      we0 = (k >= 8 && k <= 12); waddr0 = 5'd9; wdata0 = 32'hFFFFFFFF;
      clr0 = (k == 20);
      raddr0 = {5'(k < 31 ? k + 1 : 0), 5'(k - 1)}; #2;
      expect_val("clr_prev_zero", 0, 0, 32'h0);
      expect_val("clr_next_kept", 0, 1, k < 31 ? 32'((k + 1) * 3) : 32'h0);
      expect_val("clr_busy", 0, P_BUSY, 32'h1);
      expect_val("clr_done", 0, P_DONE, 32'(k == 31));
      check_all();
      tick();
    end
    we0 = 0; clr0 = 0; #2;
    expect_val("post_clr_busy", 0, P_BUSY, 32'h0);
    expect_val("post_clr_done", 0, P_DONE, 32'h0);
    check_all();
    for (int i = 0; i < 32; i++) begin
      raddr0 = {5'(31 - i), 5'(i)}; #1;
      expect_val("post_clr_p0", 0, 0, 32'h0);
      expect_val("post_clr_p1", 0, 1, 32'h0);
      check_all();
    end
    tick(); #2;
    expect_val("no_queued_clr", 0, P_BUSY, 32'h0);
    check_all();

    note("write + clear same cycle, then reset abort");
    we0 = 1; waddr0 = 5'd20; wdata0 = 32'h20; tick();
    waddr0 = 5'd4; wdata0 = 32'h55; clr0 = 1; raddr0 = {5'd20, 5'd4}; tick();
    we0 = 0; clr0 = 0; #2;
    expect_val("simul_x4_kept", 0, 0, 32'h55);
    expect_val("simul_busy", 0, P_BUSY, 32'h1);
    check_all();
    repeat (4) tick();
    #2;
    expect_val("simul_x4_cleared", 0, 0, 32'h0);
    check_all();
    repeat (5) tick();
    #2;
    expect_val("abort_pre_x20", 0, 1, 32'h20);
    expect_val("abort_pre_busy", 0, P_BUSY, 32'h1);
    check_all();
    rst_n = 1'b0; #1;
    expect_val("abort_busy", 0, P_BUSY, 32'h0);
    expect_val("abort_done", 0, P_DONE, 32'h0);
    expect_val("abort_x20", 0, 1, 32'h0);
    check_all();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 35; c++) begin
      #2;
      expect_val("abort_no_done", 0, P_DONE, 32'h0);
      expect_val("abort_idle", 0, P_BUSY, 32'h0);
      check_all();
      tick();
    end
    we0 = 1; waddr0 = 5'd3; wdata0 = 32'h33; tick();
    we0 = 0; raddr0 = {5'd0, 5'd3}; #2;
    expect_val("after_abort_x3", 0, 0, 32'h33);
    check_all();

    note("NREGS=16 NRD=3 config");
    we2 = 1; waddr2 = 4'd15; wdata2 = 32'hF; tick();
    waddr2 = 4'd1; wdata2 = 32'h1; tick();
    waddr2 = 4'd14; wdata2 = 32'hE; tick();
    waddr2 = 4'd2; wdata2 = 32'h22; raddr2 = {4'd2, 4'd1, 4'd15}; #2;
    expect_val("u2_p0_x15", 2, 0, 32'hF);
    expect_val("u2_p1_x1", 2, 1, 32'h1);
    expect_val("u2_p2_bypass", 2, 2, 32'h22);
    check_all();
    tick();
    we2 = 0; raddr2 = {4'd0, 4'd2, 4'd14}; #2;
    expect_val("u2_p0_x14", 2, 0, 32'hE);
    expect_val("u2_p1_x2", 2, 1, 32'h22);
    expect_val("u2_p2_x0", 2, 2, 32'h0);
    check_all();
    clr2 = 1; tick();
    clr2 = 0;
    bcnt = 0; dcnt = 0; dpos = -1;
    for (int c = 0; c < 20; c++) begin
      #2;
      if (busy2) bcnt++;
      if (done2) begin dcnt++; dpos = bcnt; end
      tick();
    end
    check_int("u2_busy_cycles", bcnt, 15);
    check_int("u2_done_pulses", dcnt, 1);
    check_int("u2_done_on_last", dpos, 15);
    raddr2 = {4'd15, 4'd14, 4'd1}; #2;
    expect_val("u2_clr_p0", 2, 0, 32'h0);
    expect_val("u2_clr_p1", 2, 1, 32'h0);
    expect_val("u2_clr_p2", 2, 2, 32'h0);
    check_all();

    note("NREGS=2 single-cycle clear");
    we3 = 1; waddr3 = 1'b1; wdata3 = 8'h3C; tick();
    we3 = 0; raddr3 = 1'b1; #2;
    expect_val("u3_x1", 3, 0, 32'h3C);
    check_all();
    clr3 = 1; tick();
    clr3 = 0; #2;
    expect_val("u3_busy", 3, P_BUSY, 32'h1);
    expect_val("u3_done", 3, P_DONE, 32'h1);
    expect_val("u3_x1_during", 3, 0, 32'h3C);
    check_all();
    tick(); #2;
    expect_val("u3_busy_end", 3, P_BUSY, 32'h0);
    expect_val("u3_done_end", 3, P_DONE, 32'h0);
    expect_val("u3_x1_cleared", 3, 0, 32'h0);
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
